// File: rtl/scan_vagas_pkg.sv
// Shared types and helpers for the parking-slot scanner.
package scan_vagas_pkg;

  localparam int N_SLOTS = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } state_t;

  function automatic logic [CNT_W-1:0] popcount4(input logic [N_SLOTS-1:0] v);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      sum = sum + CNT_W'(v[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/scan_vagas_if.sv
// Mux-side and display-side signals of the slot scanner.
interface scan_vagas_if;
  import scan_vagas_pkg::*;

  logic               en;
  logic               sens_w;
  logic [SEL_W-1:0]   sel;
  logic [N_SLOTS-1:0] occ;
  logic [CNT_W-1:0]   free_cnt;
  logic               full;
  logic               empty;
  logic               change;
  logic               scan_done;

  modport master (
    output en, sens_w,
    input  sel, occ, free_cnt, full, empty, change, scan_done
  );

  modport slave (
    input  en, sens_w,
    output sel, occ, free_cnt, full, empty, change, scan_done
  );

endinterface

// File: rtl/vaga_debounce.sv
// One slot's debounced occupancy bit: flips after DEB_CNT consecutive disagreeing samples.
module vaga_debounce #(
  parameter int DEB_CNT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic sens,
  output logic occ_bit,
  output logic flip
);

  localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT + 1) : 1;

  logic [DW-1:0] deb_q, deb_d, deb_inc;
  logic          occ_q, occ_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    deb_d   = deb_q;
    occ_d   = occ_q;
    flip    = 1'b0;
    deb_inc = deb_q + 1'b1;
    if (sample_en) begin
      if (sens == occ_q) begin
        deb_d = '0;
      end else if (deb_inc == DW'(DEB_CNT)) begin
        occ_d = ~occ_q;
        deb_d = '0;
        flip  = 1'b1;
      end else begin
        deb_d = deb_inc;
      end
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values; the
  // counter is reset too, since leftover history would bias the first decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '0;
      occ_q <= 1'b0;
    end else begin
      deb_q <= deb_d;
      occ_q <= occ_d;
    end
  end

  assign occ_bit = occ_q;

endmodule

// File: rtl/scan_vagas.sv
// Scans the 4:1 slot-sensor mux, debounces each slot and keeps free/full/empty status.
module scan_vagas
  import scan_vagas_pkg::*;
#(
  parameter int DWELL   = 4,
  parameter int DEB_CNT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  scan_vagas_if.slave   bus
);

  localparam int SCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t             state_q, state_d;
  logic [SCNT_W-1:0]  scnt_q, scnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   free_cnt_q, free_cnt_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               change_q, change_d;
  logic               scan_done_q, scan_done_d;

  logic [N_SLOTS-1:0] sample_en;
  logic [N_SLOTS-1:0] occ_now;
  logic [N_SLOTS-1:0] occ_nxt;
  logic [N_SLOTS-1:0] flip;

  always_comb begin
    sample_en = '0;
    if (state_q == SAMPLE) begin
      sample_en[sel_q] = 1'b1;
    end
  end

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    vaga_debounce #(
      .DEB_CNT (DEB_CNT)
    ) u_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en[i]),
      .sens      (bus.sens_w),
      .occ_bit   (occ_now[i]),
      .flip      (flip[i])
    );
  end

  // Status is derived from the post-edge occupancy so it lands together with occ.
  assign occ_nxt = occ_now ^ flip;

  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    sel_d       = sel_q;
    free_cnt_d  = CNT_W'(N_SLOTS) - popcount4(occ_nxt);
    full_d      = (free_cnt_d == '0);
    empty_d     = (free_cnt_d == CNT_W'(N_SLOTS));
    change_d    = |flip;
    scan_done_d = (state_q == SAMPLE) && (sel_q == SEL_W'(N_SLOTS - 1));

    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = SETTLE;
          scnt_d  = '0;
        end
      end
      SETTLE: begin
        // en is deliberately ignored here: a started slot always gets sampled.
        if (scnt_q == SCNT_W'(DWELL - 1)) begin
          state_d = SAMPLE;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        sel_d   = sel_q + 1'b1;
        scnt_d  = '0;
        state_d = bus.en ? SETTLE : IDLE;
      end
      default: begin
        state_d = IDLE;
        scnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scnt_q      <= '0;
      sel_q       <= '0;
      free_cnt_q  <= CNT_W'(N_SLOTS);
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      change_q    <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      sel_q       <= sel_d;
      free_cnt_q  <= free_cnt_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      change_q    <= change_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.occ       = occ_now;
  assign bus.free_cnt  = free_cnt_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.change    = change_q;
  assign bus.scan_done = scan_done_q;

endmodule

// File: tb/tb_scan_vagas.sv
// Scoreboard bench for scan_vagas: a timeline model predicts every cycle, a monitor compares.
module tb_scan_vagas;

  localparam int DWELL   = 4;
  localparam int DEB_CNT = 3;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] occ;
    logic [2:0] free_cnt;
    logic       full;
    logic       empty;
    logic       change;
    logic       scan_done;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [3:0] truth;

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];

  scan_vagas_if bus ();

  // The bench plays the role of the 4:1 mux in front of the real sensors.
  assign bus.sens_w = truth[bus.sel];

  scan_vagas #(
    .DWELL   (DWELL),
    .DEB_CNT (DEB_CNT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: the slot being scanned is sampled once every DWELL+1 cycles;
  // a slot's belief flips once DEB_CNT samples in a row disagree with it.
  int       m_phase;   // -1 idle, 0..DWELL-1 settling, DWELL sampling
  int       m_sel;
  bit [3:0] m_occ;
  int       m_streak[4];
  bit       m_change;
  bit       m_done;

  task automatic model_reset();
    m_phase  = -1;
    m_sel    = 0;
    m_occ    = '0;
    m_change = 0;
    m_done   = 0;
    for (int i = 0; i < 4; i++) m_streak[i] = 0;
  endtask

  task automatic model_step(input bit en_now, input bit [3:0] sensors);
    m_change = 0;
    m_done   = 0;
    if (m_phase < 0) begin
      if (en_now) m_phase = 0;
    end else if (m_phase < DWELL) begin
      m_phase = m_phase + 1;
    end else begin
      if (sensors[m_sel] == m_occ[m_sel]) begin
        m_streak[m_sel] = 0;
      end else begin
        m_streak[m_sel] = m_streak[m_sel] + 1;
        if (m_streak[m_sel] == DEB_CNT) begin
          m_occ[m_sel]    = ~m_occ[m_sel];
          m_streak[m_sel] = 0;
          m_change        = 1;
        end
      end
      m_done  = (m_sel == 3);
      m_sel   = (m_sel + 1) % 4;
      m_phase = en_now ? 0 : -1;
    end
  endtask

  function automatic exp_t model_view();
    exp_t e;
    int   occupied;
    occupied = 0;
    for (int i = 0; i < 4; i++) occupied += int'(m_occ[i]);
    e.sel       = 2'(m_sel);
    e.occ       = m_occ;
    e.free_cnt  = 3'(4 - occupied);
    e.full      = (occupied == 4);
    e.empty     = (occupied == 0);
    e.change    = m_change;
    e.scan_done = m_done;
    return e;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step(bus.en, truth);
      exp_q.push_back(model_view());
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sel",       32'(bus.sel),       32'(e.sel));
        check("occ",       32'(bus.occ),       32'(e.occ));
        check("free_cnt",  32'(bus.free_cnt),  32'(e.free_cnt));
        check("full",      32'(bus.full),      32'(e.full));
        check("empty",     32'(bus.empty),     32'(e.empty));
        check("change",    32'(bus.change),    32'(e.change));
        check("scan_done", 32'(bus.scan_done), 32'(e.scan_done));
      end
      check("full_and_empty", 32'(bus.full & bus.empty), 32'd0);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sel(input logic [1:0] target, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.sel == target) found = 1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  initial begin
    rst_n  = 1'b0;
    bus.en = 1'b0;
    truth  = 4'b0000;
    run(3);
    rst_n = 1'b1;

    // Idle after reset: nothing may move.
    run(50);

    // Only slot 2 occupied.
    bus.en = 1'b1;
    truth  = 4'b0100;
    run(70);

    // Slot 1 glitches for two scans, then clears.
    truth = 4'b0110;
    run(40);
    truth = 4'b0100;
    run(40);

    // Lot fills up.
    truth = 4'b1111;
    run(70);

    // Drop en while slot 1 is settling.
    wait_sel(2'd1, "wait_sel1");
    bus.en = 1'b0;
    run(15);
    check("sel_frozen_after_drop", 32'(bus.sel), 32'd2);
    bus.en = 1'b1;
    run(30);

    // Learn 1010, then reset in the middle of a settle.
    truth = 4'b1010;
    run(80);
    check("occ_before_reset", 32'(bus.occ), 32'b1010);
    wait_sel(2'd3, "wait_sel3");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_sel",       32'(bus.sel),       32'd0);
    check("async_occ",       32'(bus.occ),       32'd0);
    check("async_free_cnt",  32'(bus.free_cnt),  32'd4);
    check("async_full",      32'(bus.full),      32'd0);
    check("async_empty",     32'(bus.empty),     32'd1);
    check("async_change",    32'(bus.change),    32'd0);
    check("async_scan_done", 32'(bus.scan_done), 32'd0);
    run(2);
    rst_n = 1'b1;
    run(70);

    // Random en gating and slowly changing sensors with occasional glitches.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (bus.en) begin
        if ($urandom_range(0, 99) < 2) bus.en = 1'b0;
      end else if ($urandom_range(0, 99) < 20) begin
        bus.en = 1'b1;
      end
      for (int s = 0; s < 4; s++) begin
        if ($urandom_range(0, 99) < 2) truth[s] = ~truth[s];
      end
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
